// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//
// Contents:
//   WORD_SIZE, FETCH_SIZE  default address and line widths
//   TIMEOUT_DEFAULT        default watchdog limit in MEM cycles
//   TMO_CNT_W              width of the watchdog counter
//   arb_state_e            arbiter FSM state encoding
//   src_e                  requesting-port identifier
//   other_src()            the port that is not the given one
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_SIZE       = 16;
  localparam int unsigned FETCH_SIZE      = 64;
  localparam int unsigned TIMEOUT_DEFAULT = 32;
  localparam int unsigned TMO_CNT_W       = 6;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    if (s == SRC_I) begin
      return SRC_D;
    end
    return SRC_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-requester round-robin picker for the memory port arbiter.
//
// Purely combinational. The grant output is only meaningful when at least
// one request is set; with no request it defaults to the i-port.
//
// Ports:
//   req_i       i-cache port is pending
//   req_d       d-cache port is pending
//   last_grant  port that owned the most recent completed transaction
//   grant       port chosen for the next transaction
module rr_grant2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  src_e last_grant,
  output src_e grant
);

  always_comb begin
    grant = SRC_I;
    if (req_i && req_d) begin
      // Tie: whoever did not go last goes now.
      grant = other_src(last_grant);
    end else if (req_d) begin
      grant = SRC_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: serialises i-cache line reads and d-cache line
// reads/writes onto one line-wide memory port.
//
// A transaction is latched in IDLE (source, line-aligned address, direction,
// write line), presented on the memory port in MEM until mem_ready or the
// watchdog expires, and completed in RESP with a one-cycle ack to the owner.
// Every transaction passes through IDLE again, so a port is never resampled
// in the cycle its ack is high.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   i_readM, i_writeM            i-cache read request / ignored write request
//   i_addressM                   i-cache line address
//   i_rdata, i_ack               i-cache line data (valid with ack), ack pulse
//   d_readM, d_writeM            d-cache read / write request (write wins)
//   d_addressM, d_wdata          d-cache line address and write line
//   d_rdata, d_ack               d-cache line data (valid with ack), ack pulse
//   mem_req, mem_we              memory request, direction (1 = write)
//   mem_address, mem_wdata       line-aligned address, write line
//   mem_rdata, mem_ready         read line, one-cycle completion
//   err_timeout                  sticky watchdog flag, cleared by reset only
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE  = mem_port_arbiter_pkg::WORD_SIZE,
  parameter int unsigned FETCH_SIZE = mem_port_arbiter_pkg::FETCH_SIZE,
  parameter int unsigned TIMEOUT    = mem_port_arbiter_pkg::TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_readM,
  input  logic                  i_writeM,
  input  logic [WORD_SIZE-1:0]  i_addressM,
  output logic [FETCH_SIZE-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  input  logic [WORD_SIZE-1:0]  d_addressM,
  input  logic [FETCH_SIZE-1:0] d_wdata,
  output logic [FETCH_SIZE-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_address,
  output logic [FETCH_SIZE-1:0] mem_wdata,
  input  logic [FETCH_SIZE-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err_timeout
);

  import mem_port_arbiter_pkg::*;

  // Counter value seen in the last MEM cycle the watchdog allows.
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  src_e                  owner_q, owner_d;
  src_e                  last_q, last_d;
  src_e                  grant;
  logic                  we_q, we_d;
  logic [WORD_SIZE-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0]  sel_addr;
  logic [FETCH_SIZE-1:0] wdata_q, wdata_d;
  logic [FETCH_SIZE-1:0] rdata_q, rdata_d;
  logic [TMO_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  i_pend, d_pend;
  logic                  in_mem, in_resp;

  // i_writeM is architecturally ignored; low address bits are forced to zero.
  logic unused_inputs;
  assign unused_inputs = ^{i_writeM, i_addressM[1:0], d_addressM[1:0]};

  assign i_pend = i_readM;
  assign d_pend = d_readM | d_writeM;

  rr_grant2 u_rr_grant2 (
    .req_i      (i_pend),
    .req_d      (d_pend),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign sel_addr = (grant == SRC_D) ? d_addressM : i_addressM;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      ARB_IDLE: begin
        if (i_pend || d_pend) begin
          owner_d = grant;
          we_d    = (grant == SRC_D) && d_writeM;
          addr_d  = {sel_addr[WORD_SIZE-1:2], 2'b00};
          wdata_d = ((grant == SRC_D) && d_writeM) ? d_wdata : '0;
          cnt_d   = '0;
          state_d = ARB_MEM;
        end
      end

      ARB_MEM: begin
        if (mem_ready) begin
          // Writes hand back an all-zero line.
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = ARB_RESP;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ARB_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ARB_RESP: begin
        last_d  = owner_q;
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= SRC_I;
      last_q  <= SRC_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_mem  = (state_q == ARB_MEM);
  assign in_resp = (state_q == ARB_RESP);

  // Port outputs are zero whenever they carry no meaning.
  assign mem_req     = in_mem;
  assign mem_we      = in_mem & we_q;
  assign mem_address = in_mem ? addr_q : '0;
  assign mem_wdata   = in_mem ? wdata_q : '0;

  assign i_ack   = in_resp && (owner_q == SRC_I);
  assign d_ack   = in_resp && (owner_q == SRC_D);
  assign i_rdata = i_ack ? rdata_q : '0;
  assign d_rdata = d_ack ? rdata_q : '0;

  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int WS  = 16;
  localparam int FS  = 64;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_readM = 1'b0, i_writeM = 1'b0;
  logic [WS-1:0] i_addressM = '0;
  logic [FS-1:0] i_rdata;
  logic          i_ack;
  logic          d_readM = 1'b0, d_writeM = 1'b0;
  logic [WS-1:0] d_addressM = '0;
  logic [FS-1:0] d_wdata = '0;
  logic [FS-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req, mem_we;
  logic [WS-1:0] mem_address;
  logic [FS-1:0] mem_wdata;
  logic [FS-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          err_timeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_SIZE  (WS),
    .FETCH_SIZE (FS),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_readM     (i_readM),
    .i_writeM    (i_writeM),
    .i_addressM  (i_addressM),
    .i_rdata     (i_rdata),
    .i_ack       (i_ack),
    .d_readM     (d_readM),
    .d_writeM    (d_writeM),
    .d_addressM  (d_addressM),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .err_timeout (err_timeout)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no transaction, 1 = line on the port,
  // 2 = completion cycle. m_waited counts finished MEM cycles.
  int          m_phase = 0;
  bit          m_owner_d = 0;
  bit          m_last_d = 0;
  bit          m_we = 0;
  logic [15:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [63:0] m_line = '0;
  int          m_waited = 0;
  bit          m_err = 0;

  initial forever begin : model
    bit pi, pd;
    @(posedge clk);
    pi = i_readM;
    pd = d_readM | d_writeM;
    if (reset) begin
      m_phase  = 0;
      m_last_d = 0;
      m_err    = 0;
    end else if (m_phase == 0) begin
      if (pi || pd) begin
        m_owner_d = (pi && pd) ? !m_last_d : pd;
        m_we      = m_owner_d && d_writeM;
        m_addr    = (m_owner_d ? d_addressM : i_addressM) & 16'hFFFC;
        m_wdata   = d_wdata;
        m_waited  = 0;
        m_phase   = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ready) begin
        m_line  = m_we ? 64'd0 : mem_rdata;
        m_phase = 2;
      end else begin
        m_waited++;
        if (m_waited >= TMO) begin
          m_err   = 1;
          m_line  = 64'd0;
          m_phase = 2;
        end
      end
    end else begin
      m_last_d = m_owner_d;
      m_phase  = 0;
    end
  end

  bit ack_log[$];

  initial forever begin : compare
    @(negedge clk);
    if (chk_en) begin
      check("mdl_mem_req", mem_req, m_phase == 1);
      check("mdl_err_timeout", err_timeout, m_err);
      check("mdl_i_ack", i_ack, (m_phase == 2) && !m_owner_d);
      check("mdl_d_ack", d_ack, (m_phase == 2) && m_owner_d);
      if (m_phase == 1) begin
        check("mdl_mem_we", mem_we, m_we);
        check("mdl_mem_address", mem_address, m_addr);
        if (m_we) check("mdl_mem_wdata", mem_wdata, m_wdata);
      end
      if (m_phase == 2) begin
        if (m_owner_d) check("mdl_d_rdata", d_rdata, m_line);
        else           check("mdl_i_rdata", i_rdata, m_line);
      end
      if (i_ack) ack_log.push_back(1'b0);
      if (d_ack) ack_log.push_back(1'b1);
    end
  end

  // Memory responder: mem_ready in the mem_lat-th cycle of mem_req; 0 = never.
  int mem_lat = 1;
  int mem_cnt = 0;

  initial forever begin : responder
    @(posedge clk);
    #1;
    if (mem_req) begin
      mem_cnt++;
      mem_ready = (mem_lat != 0) && (mem_cnt == mem_lat);
    end else begin
      mem_cnt   = 0;
      mem_ready = 1'b0;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // which: 0 mem_req, 1 i_ack, 2 d_ack, 3 either ack. n = posedges taken.
  task automatic wait_for(input int which, input int limit, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      case (which)
        0:       hit = mem_req;
        1:       hit = i_ack;
        2:       hit = d_ack;
        default: hit = i_ack | d_ack;
      endcase
    end
    check("wait_bound", hit, 1'b1);
  endtask

  initial begin : stimulus
    int n;
    bit rr_exp[4];
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};

    step(3);
    chk_en = 1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_mem_address", mem_address, 16'h0000);
    reset = 1'b0;
    step(2);

    // Single i read, mem_ready two cycles after mem_req rises.
    mem_lat    = 3;
    mem_rdata  = 64'h0004_0003_0002_0001;
    i_addressM = 16'h0013;
    i_readM    = 1'b1;
    wait_for(0, 10, n);
    check("t1_mem_address", mem_address, 16'h0010);
    check("t1_mem_we", mem_we, 1'b0);
    wait_for(1, 10, n);
    check("t1_i_rdata", i_rdata, 64'h0004_0003_0002_0001);
    check("t1_d_ack", d_ack, 1'b0);
    i_readM = 1'b0;
    step(2);

    // Tie right after reset history: d write first, then i read.
    mem_lat    = 2;
    d_addressM = 16'h0020;
    d_wdata    = 64'hAAAA_BBBB_CCCC_DDDD;
    d_writeM   = 1'b1;
    i_addressM = 16'h0040;
    i_readM    = 1'b1;
    wait_for(0, 10, n);
    check("t2_mem_we", mem_we, 1'b1);
    check("t2_mem_address", mem_address, 16'h0020);
    check("t2_mem_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    wait_for(2, 10, n);
    check("t2_d_rdata", d_rdata, 64'h0);
    check("t2_i_ack_quiet", i_ack, 1'b0);
    d_writeM = 1'b0;
    step(1);
    check("t2_idle_gap", mem_req, 1'b0);
    step(1);
    check("t2_i_mem_req", mem_req, 1'b1);
    check("t2_i_mem_address", mem_address, 16'h0040);
    wait_for(1, 10, n);
    i_readM = 1'b0;
    step(2);

    // Round-robin with both ports held busy.
    ack_log.delete();
    mem_lat    = 1;
    d_addressM = 16'h0100;
    i_addressM = 16'h0200;
    d_readM    = 1'b1;
    i_readM    = 1'b1;
    for (int k = 0; k < 4; k++) wait_for(3, 10, n);
    d_readM = 1'b0;
    i_readM = 1'b0;
    step(2);
    check("t3_ack_count", ack_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_log.size()) check("t3_rr_order", ack_log[k], rr_exp[k]);
    end

    // Watchdog: memory never answers a d read.
    mem_lat    = 0;
    mem_rdata  = 64'hDEAD_BEEF_0000_0001;
    d_addressM = 16'h0303;
    d_readM    = 1'b1;
    wait_for(2, 60, n);
    check("t4_timeout_latency", n, 33);
    check("t4_err", err_timeout, 1'b1);
    check("t4_d_rdata", d_rdata, 64'h0);
    d_readM = 1'b0;
    step(2);
    mem_lat    = 1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    i_addressM = 16'h0080;
    i_readM    = 1'b1;
    wait_for(1, 10, n);
    check("t4_i_rdata", i_rdata, 64'h1111_2222_3333_4444);
    check("t4_err_sticky", err_timeout, 1'b1);
    i_readM = 1'b0;
    step(2);

    // Reset while the port is busy.
    mem_lat    = 0;
    i_addressM = 16'h0404;
    i_readM    = 1'b1;
    wait_for(0, 10, n);
    step(3);
    reset   = 1'b1;
    i_readM = 1'b0;
    step(1);
    check("t5_mem_req", mem_req, 1'b0);
    check("t5_i_ack", i_ack, 1'b0);
    check("t5_d_ack", d_ack, 1'b0);
    check("t5_err", err_timeout, 1'b0);
    reset     = 1'b0;
    mem_lat   = 1;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    i_readM   = 1'b1;
    wait_for(1, 10, n);
    check("t5_latency", n, 2);
    check("t5_i_rdata", i_rdata, 64'h0123_4567_89AB_CDEF);
    i_readM = 1'b0;
    step(2);

    // Illegal i write is never pending; d read+write resolves to write.
    i_writeM = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("t6_no_req", mem_req, 1'b0);
      check("t6_no_i_ack", i_ack, 1'b0);
    end
    i_writeM   = 1'b0;
    d_addressM = 16'h050A;
    d_wdata    = 64'h5555_6666_7777_8888;
    d_readM    = 1'b1;
    d_writeM   = 1'b1;
    wait_for(0, 10, n);
    check("t6_mem_we", mem_we, 1'b1);
    check("t6_mem_address", mem_address, 16'h0508);
    wait_for(2, 10, n);
    d_readM  = 1'b0;
    d_writeM = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
